// File: rtl/seq_multiplier_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_multiplier_if
//  Brief    : Operand/result handshake bundle for seq_multiplier.
//             acc_en is present only when MULT_ACC_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_multiplier_if #(
    parameter int a0_width  = 8,
    parameter int a1_width  = 8,
    parameter int out_width = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [a0_width-1:0]  a0;
    logic [a1_width-1:0]  a1;
    logic                 is_signed;
`ifdef MULT_ACC_EN
    logic                 acc_en;
`endif
    logic                 out_valid;
    logic                 out_ready;
    logic [out_width-1:0] product;

    // Operand source / result sink side
    modport master (
`ifdef MULT_ACC_EN
        output acc_en,
`endif
        output in_valid, a0, a1, is_signed, out_ready,
        input  in_ready, out_valid, product
    );

    // Multiplier side
    modport slave (
`ifdef MULT_ACC_EN
        input  acc_en,
`endif
        input  in_valid, a0, a1, is_signed, out_ready,
        output in_ready, out_valid, product
    );
endinterface
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : seq_multiplier
//  Brief    : Multi-cycle shift-add multiplier, one multiplier bit per cycle,
//             signed/unsigned per operation, valid/ready on both sides.
//             Optional accumulator enabled by the MULT_ACC_EN macro.
//  Revision : 1.0  initial release
// ============================================================================
module seq_multiplier #(
`ifdef MULT_ACC_EN
    parameter int acc_guard = 8,
`endif
    parameter int a0_width = 8,
    parameter int a1_width = 8
) (
    input  wire              clk,
    input  wire              rst,
    seq_multiplier_if.slave  bus
);
    localparam int product_width = a0_width + a1_width;
    localparam int c_cnt_w       = $clog2(a1_width + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(a1_width);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     w_in_ready;
    logic                     w_out_valid;
    logic                     w_accept;

    logic [c_cnt_w-1:0]       r_cnt;
    logic [product_width-1:0] r_mcand;   // extended multiplicand, shifted left per iteration
    logic [a1_width-1:0]      r_mplier;  // multiplier, shifted right so bit 0 is current
    logic [product_width-1:0] r_sum;
    logic                     r_signed;

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode; both handshake outputs depend on state only
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;

    // Operand capture and one shift-add step per BUSY cycle; the MSB step
    // (counter at 1) subtracts in signed mode to give it weight -2^(w-1)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_sum    <= '0;
            r_signed <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= bus.is_signed
                        ? {{a1_width{bus.a0[a0_width-1]}}, bus.a0}
                        : {{a1_width{1'b0}}, bus.a0};
            r_mplier <= bus.a1;
            r_sum    <= '0;
            r_cnt    <= c_cnt_init;
            r_signed <= bus.is_signed;
        end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
            if (r_mplier[0]) begin
                if (r_signed && (r_cnt == c_cnt_w'(1))) begin
                    r_sum <= r_sum - r_mcand;
                end else begin
                    r_sum <= r_sum + r_mcand;
                end
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - c_cnt_w'(1);
        end
    end

`ifdef MULT_ACC_EN
    localparam int c_acc_w = product_width + acc_guard;

    logic               r_acc_en;
    logic [c_acc_w-1:0] r_acc;
    logic [c_acc_w-1:0] w_ext;

    assign w_ext = r_signed ? {{acc_guard{r_sum[product_width-1]}}, r_sum}
                            : {{acc_guard{1'b0}}, r_sum};

    // Accumulator updates once, on the BUSY-to-DONE transition; wraps silently
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_acc_en <= 1'b0;
        end else if (w_accept) begin
            r_acc_en <= bus.acc_en;
        end else if ((r_state == S_BUSY) && (r_cnt == '0)) begin
            r_acc <= r_acc_en ? (r_acc + w_ext) : w_ext;
        end
    end

    assign bus.product = r_acc;
`else
    logic [product_width-1:0] r_prod;

    // Result register, loaded on the BUSY-to-DONE transition and held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod <= '0;
        end else if ((r_state == S_BUSY) && (r_cnt == '0)) begin
            r_prod <= r_sum;
        end
    end

    assign bus.product = r_prod;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_multiplier
//  Brief    : Self-checking bench for seq_multiplier (scoreboard based).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_multiplier;
    localparam int AW = 8;
    localparam int BW = 8;
    localparam int PW = AW + BW;
`ifdef MULT_ACC_EN
    localparam int GW = 8;
`else
    localparam int GW = 0;
`endif
    localparam int OW = PW + GW;
    localparam int LAT = BW + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_multiplier_if #(.a0_width(AW), .a1_width(BW), .out_width(OW)) bus ();

    seq_multiplier #(
`ifdef MULT_ACC_EN
        .acc_guard(GW),
`endif
        .a0_width(AW),
        .a1_width(BW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [OW-1:0] sb[$];
    logic [OW-1:0] acc_model = '0;

    function automatic logic [OW-1:0] model(input logic [AW-1:0] x, input logic [BW-1:0] y,
                                            input logic s);
        logic        [PW-1:0] p;
        logic signed [PW-1:0] ps;
        if (s) begin
            ps = $signed(x) * $signed(y);
            return OW'(ps);
        end
        p = {{BW{1'b0}}, x} * {{AW{1'b0}}, y};
        return OW'(p);
    endfunction

    task automatic issue(input logic [AW-1:0] x, input logic [BW-1:0] y,
                         input logic s, input logic ae);
        int g = 0;
        bus.a0 = x; bus.a1 = y; bus.is_signed = s;
`ifdef MULT_ACC_EN
        bus.acc_en = ae;
`endif
        bus.in_valid = 1'b1;
        while (!bus.in_ready && g < 50) begin
            @(posedge clk); #1; g++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            $display("FAIL issue_timeout in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
`ifdef MULT_ACC_EN
        acc_model = ae ? acc_model + model(x, y, s) : model(x, y, s);
        sb.push_back(acc_model);
`else
        if (ae) acc_model = acc_model + model(x, y, s);
        sb.push_back(model(x, y, s));
`endif
    endtask

    task automatic wait_result(output logic [OW-1:0] got, output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        got = bus.product;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        acc_model = '0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b required 1", bus.in_ready);
        else n_pass++;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b required 0", bus.out_valid);
        else n_pass++;
        n_checks++;
        if (bus.product !== '0) $display("FAIL reset_product got %h required 0", bus.product);
        else n_pass++;
    endtask

    // Fixed vectors from the known-answer list, checked for value and latency
    task automatic test_known(input string name, input logic [AW-1:0] x, input logic [BW-1:0] y,
                              input logic s, input logic [PW-1:0] want);
        logic [OW-1:0] got, exp;
        int n;
        issue(x, y, s, 1'b0);
        wait_result(got, n);
        exp = sb.pop_front();
        n_checks++;
        if (n !== LAT) $display("FAIL %s_latency got %0d required %0d", name, n, LAT);
        else n_pass++;
        n_checks++;
        if (got !== exp) $display("FAIL %s_scoreboard got %h required %h", name, got, exp);
        else n_pass++;
        n_checks++;
        if (got[PW-1:0] !== want) $display("FAIL %s_value got %h required %h", name, got[PW-1:0], want);
        else n_pass++;
        consume();
    endtask

    task automatic test_unsigned();
        test_known("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        test_known("u_0_a5",  8'h00, 8'hA5, 1'b0, 16'h0000);
    endtask

    task automatic test_signed();
        test_known("s_m3_5",     8'hFD, 8'h05, 1'b1, 16'hFFF1);
        test_known("s_m128_m128", 8'h80, 8'h80, 1'b1, 16'h4000);
        test_known("s_127_m1",   8'h7F, 8'hFF, 1'b1, 16'hFF81);
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] got, exp, held;
        int n;
        bit ok;
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        wait_result(got, n);
        held = got;
        exp  = sb.pop_front();
        n_checks++;
        if (got !== exp) $display("FAIL bp_value got %h required %h", got, exp);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.a0 = 8'h55; bus.a1 = 8'h66;
            @(posedge clk); #1;
            n_checks++;
            if (bus.product !== held || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
                $display("FAIL bp_hold cycle %0d product=%h in_ready=%b out_valid=%b required %h/0/1",
                         i, bus.product, bus.in_ready, bus.out_valid, held);
            else n_pass++;
        end
        bus.in_valid = 1'b0;
        consume();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL bp_release out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
        else n_pass++;
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) ok = 1'b0;
        end
        n_checks++;
        if (!ok) $display("FAIL bp_ghost_op out_valid seen required none");
        else n_pass++;
    endtask

    task automatic test_reset_busy();
        bit ok;
        issue(8'h0F, 8'h0F, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_front());
        acc_model = '0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL rstbusy_idle in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        else n_pass++;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) ok = 1'b0;
        end
        n_checks++;
        if (!ok) $display("FAIL rstbusy_emitted out_valid seen required none");
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] got, exp;
        logic [AW-1:0] x;
        logic [BW-1:0] y;
        logic s;
        int n;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            x = AW'($urandom);
            y = BW'($urandom);
            s = 1'($urandom_range(0, 1));
            issue(x, y, s, 1'b0);
            wait_result(got, n);
            exp = sb.pop_front();
            n_checks++;
            if (n !== LAT || got !== exp)
                $display("FAIL b2b_%0d a0=%h a1=%h s=%b got %h lat %0d required %h lat %0d",
                         i, x, y, s, got, n, exp, LAT);
            else n_pass++;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
    endtask

`ifdef MULT_ACC_EN
    task automatic test_accumulate();
        logic [OW-1:0] got, exp;
        logic [AW-1:0] xs[3] = '{8'd3, 8'd5, 8'hFE};
        logic [BW-1:0] ys[3] = '{8'd4, 8'd6, 8'd7};
        logic          ss[3] = '{1'b0, 1'b0, 1'b1};
        logic          es[3] = '{1'b0, 1'b1, 1'b1};
        logic [OW-1:0] ws[3] = '{24'd12, 24'd42, 24'd28};
        int n;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            issue(xs[i], ys[i], ss[i], es[i]);
            wait_result(got, n);
            exp = sb.pop_front();
            n_checks++;
            if (got !== ws[i] || got !== exp)
                $display("FAIL acc_seq_%0d got %h required %h", i, got, ws[i]);
            else n_pass++;
            consume();
        end
        ok = 1'b1;
        for (int i = 0; i < 260; i++) begin
            issue(8'hFF, 8'hFF, 1'b0, 1'b1);
            wait_result(got, n);
            exp = sb.pop_front();
            if (got !== exp) begin
                if (ok) $display("FAIL acc_wrap_%0d got %h required %h", i, got, exp);
                ok = 1'b0;
            end
            consume();
        end
        n_checks++;
        if (ok) n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a0 = '0; bus.a1 = '0; bus.is_signed = 1'b0;
`ifdef MULT_ACC_EN
        bus.acc_en = 1'b0;
`endif
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_reset_busy();
        test_back_to_back();
`ifdef MULT_ACC_EN
        test_accumulate();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
